data_memory_arbiter: RTL

Shares the single-port 128x8 data memory between two requesters: port 0, the core's load/store/MOV sequencer, and port 1, a loader/debug port. It replaces direct strobing of the memory by the core. Each access is serialised into a fixed setup/strobe/wait/ack sequence on the memory's `lineNumber`/`memIn`/`memRead`/`memWrite`/`memOut` pins. Round-robin arbitration applies, plus a lock so a read-then-write pair (MOV) is atomic.

---
 rtl/data_memory_arbiter_pkg.sv | 6 +
 rtl/data_memory_arbiter_pick.sv | 15 +
 rtl/data_memory_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: FSM encoding and memory geometry shared with the core sequencer
package data_memory_arbiter_pkg;
  localparam int MEM_ADDR_WIDTH = 7;
  localparam int MEM_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, ACK} arbState_t;
endpackage

// File: rtl/data_memory_arbiter_pick.sv
// round_robin_pick2: two-way round-robin choice; a held lock restricts eligibility to the owner
module round_robin_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic lastGrant,
  input  logic lockHeld,
  input  logic owner,
  output logic grantValid,
  output logic grantId
);
  always_comb begin
    grantValid = lockHeld ? (owner ? req1 : req0) : (req0 | req1);
    grantId    = lockHeld ? owner : (req0 & req1) ? ~lastGrant : req1;
  end
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: serialises two requesters onto the single-port data memory
// using round-robin arbitration plus a lock that keeps read-then-write pairs atomic.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] memOut,
  output logic [DATA_WIDTH-1:0] memIn,
  output logic [ADDR_WIDTH-1:0] lineNumber,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  busy,
  output logic                  grantId
);
  arbState_t state, nextState;
  logic grantValid, pickId, weR, lastGrant, lockHeld, ownerReq, ownerLock, pickWe;
  round_robin_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .lastGrant (lastGrant),
    .lockHeld  (lockHeld),
    .owner     (grantId),
    .grantValid(grantValid),
    .grantId   (pickId)
  );
  assign busy      = state != IDLE;
  assign ownerReq  = grantId ? req1 : req0;
  assign ownerLock = grantId ? lock1 : lock0;
  assign pickWe    = pickId ? we1 : we0;
  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state == IDLE   ? (grantValid ? SETUP : IDLE) :
                state == SETUP  ? STROBE :
                state == STROBE ? WAIT :
                state == WAIT   ? ACK : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstN) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      memRead    <= 1'b0;
      memWrite   <= 1'b0;
      lineNumber <= '0;
      memIn      <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      grantId    <= 1'b0;
      weR        <= 1'b0;
      lastGrant  <= 1'b1;
      lockHeld   <= 1'b0;
    end else begin
      ack0     <= state == WAIT && !grantId;
      ack1     <= state == WAIT && grantId;
      memRead  <= state == SETUP && !weR;
      memWrite <= state == SETUP && weR;
      // Latching on the grant edge puts address and data on the pins throughout SETUP
      if (state == IDLE && grantValid) begin
        grantId    <= pickId;
        weR        <= pickWe;
        lineNumber <= pickId ? addr1 : addr0;
        if (pickWe) memIn <= pickId ? wdata1 : wdata0;
      end
      if (state == IDLE && lockHeld && !ownerReq && !ownerLock) lockHeld <= 1'b0;
      if (state == WAIT && !weR) begin
        if (grantId) rdata1 <= memOut;
        else rdata0 <= memOut;
      end
      if (state == ACK) begin
        lastGrant <= grantId;
        lockHeld  <= ownerLock;
      end
    end
  end
endmodule
